// File: rtl/imem_fetch_port_if.sv
// Fetch/response handshake and loader write port bundle for imem_fetch_port.
// master = fetch unit / decode / loader side, slave = the memory.
interface imem_fetch_port_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  req;
    logic                  req_ready;
    logic [ADDR_W-1:0]     addr;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_W-1:0]     rdata;
    logic                  rerr;
    logic                  we;
    logic [ADDR_W-1:0]     waddr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  wr_err;

    modport master (
        output req, addr, rready, we, waddr, wdata, wstrb,
        input  req_ready, rvalid, rdata, rerr, wr_err
    );

    modport slave (
        input  req, addr, rready, we, waddr, wdata, wstrb,
        output req_ready, rvalid, rdata, rerr, wr_err
    );
endinterface

// File: rtl/imem_fetch_port.sv
// Parametrised instruction memory with registered valid/ready fetch response,
// byte-strobed loader write port and fetch counter. Define IMEM_PARITY_EN for per-byte parity.
module imem_fetch_port #(
    parameter int    DATA_W    = 32,
    parameter int    DEPTH     = 1024,
    parameter int    ADDR_W    = 32,
    parameter int    CNT_W     = 32,
    parameter string INIT_FILE = ""
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    imem_fetch_port_if.slave   bus,
    output logic [CNT_W-1:0]   fetch_cnt_o
);
    localparam int NB    = DATA_W / 8;
    localparam int LSB   = $clog2(NB);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {EMPTY, FULL} state_t;

    state_t state, state_next;
    logic   accept;

    logic [DATA_W-1:0] mem [DEPTH];
`ifdef IMEM_PARITY_EN
    logic [NB-1:0]     mem_par [DEPTH];
`endif

    logic [ADDR_W-1:0] ridx_full, widx_full;
    logic [IDX_W-1:0]  ridx, widx;
    logic              rd_bad, wr_oor, rd_perr;
    logic [DATA_W-1:0] rd_word;

    assign ridx_full = bus.addr >> LSB;
    assign widx_full = bus.waddr >> LSB;
    assign ridx      = ridx_full[IDX_W-1:0];
    assign widx      = widx_full[IDX_W-1:0];
    assign rd_bad    = (|bus.addr[LSB-1:0]) || (ridx_full >= ADDR_W'(DEPTH));
    assign wr_oor    = (widx_full >= ADDR_W'(DEPTH));

    // Erroring fetches never touch the array, so a bad index cannot select a word.
    always_comb begin
        rd_word = '0;
        rd_perr = 1'b0;
        if (!rd_bad) begin
            rd_word = mem[ridx];
`ifdef IMEM_PARITY_EN
            for (int b = 0; b < NB; b++) begin
                rd_perr = rd_perr | ((^rd_word[b*8 +: 8]) ^ mem_par[ridx][b]);
            end
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        bus.req_ready = (state == EMPTY) || bus.rready;
        accept        = bus.req && bus.req_ready;
        case (state)
            EMPTY: if (accept) state_next = FULL;
            FULL: begin
                if (accept)           state_next = FULL;
                else if (bus.rready)  state_next = EMPTY;
            end
            default: state_next = EMPTY;
        endcase
    end

    assign bus.rvalid = (state == FULL);

    // Response register only loads on accept, so it holds steady under back-pressure.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus.rdata   <= '0;
            bus.rerr    <= 1'b0;
            fetch_cnt_o <= '0;
        end else if (accept) begin
            bus.rdata   <= rd_word;
            bus.rerr    <= rd_bad || rd_perr;
            fetch_cnt_o <= fetch_cnt_o + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus.wr_err <= 1'b0;
        end else begin
            bus.wr_err <= bus.we && (|bus.wstrb) && wr_oor;
        end
    end

    // Non-blocking writes give read-before-write against a same-cycle fetch.
    always_ff @(posedge clk_i) begin
        if (bus.we && !wr_oor) begin
            for (int b = 0; b < NB; b++) begin
                if (bus.wstrb[b]) begin
                    mem[widx][b*8 +: 8] <= bus.wdata[b*8 +: 8];
`ifdef IMEM_PARITY_EN
                    mem_par[widx][b]    <= ^bus.wdata[b*8 +: 8];
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_imem_fetch_port.sv
// Randomised bench for imem_fetch_port against a word-array/queue-level model,
// plus directed cases with literal expectations.
module tb_imem_fetch_port;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 1024;
    localparam int CW    = 8;
`ifdef IMEM_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic          clk_i;
    logic          rst_ni;
    logic [CW-1:0] fetch_cnt;

    imem_fetch_port_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    imem_fetch_port #(
        .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .CNT_W(CW), .INIT_FILE("")
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .bus         (bus),
        .fetch_cnt_o (fetch_cnt)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle's worth of inputs, just after the active edge.
    task automatic applyStimulus(input logic req, input logic [31:0] addr, input logic rready,
                                 input logic we, input logic [31:0] waddr,
                                 input logic [31:0] wdata, input logic [3:0] wstrb);
        @(posedge clk_i);
        #1;
        bus.req    = req;
        bus.addr   = addr;
        bus.rready = rready;
        bus.we     = we;
        bus.waddr  = waddr;
        bus.wdata  = wdata;
        bus.wstrb  = wstrb;
    endtask

    task automatic idle(input logic rready);
        applyStimulus(1'b0, 32'h0, rready, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic fetch(input logic [31:0] addr, input logic rready);
        applyStimulus(1'b1, addr, rready, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    // Reference model: memory as a word array, response slot as valid/data/err.
    logic [31:0]   model_mem  [DEPTH];
    bit            model_perr [DEPTH];
    logic          exp_valid, exp_err, exp_wr_err;
    logic [31:0]   exp_data;
    logic [CW-1:0] exp_cnt;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i]  = 32'h0;
            model_perr[i] = 1'b0;
        end
    end

    always @(negedge clk_i) begin : compare_and_model
        logic [31:0] ridx, widx;
        logic        rbad, acc;
        if (!rst_ni) begin
            exp_valid  = 1'b0;
            exp_data   = 32'h0;
            exp_err    = 1'b0;
            exp_cnt    = '0;
            exp_wr_err = 1'b0;
        end else begin
            checkOutput("rvalid", 32'(bus.rvalid), 32'(exp_valid));
            checkOutput("req_ready", 32'(bus.req_ready), 32'(!exp_valid || bus.rready));
            checkOutput("fetch_cnt", 32'(fetch_cnt), 32'(exp_cnt));
            checkOutput("wr_err", 32'(bus.wr_err), 32'(exp_wr_err));
            if (exp_valid) begin
                checkOutput("rdata", bus.rdata, exp_data);
                checkOutput("rerr", 32'(bus.rerr), 32'(exp_err));
            end
            acc  = bus.req && (!exp_valid || bus.rready);
            ridx = bus.addr >> 2;
            rbad = (bus.addr[1:0] != 2'b00) || (ridx >= DEPTH);
            if (acc) begin
                exp_valid = 1'b1;
                exp_data  = rbad ? 32'h0 : model_mem[ridx[9:0]];
                exp_err   = rbad || (PAR && model_perr[ridx[9:0]]);
                exp_cnt   = exp_cnt + 1'b1;
            end else if (bus.rready) begin
                exp_valid = 1'b0;
            end
            widx       = bus.waddr >> 2;
            exp_wr_err = bus.we && (bus.wstrb != 4'h0) && (widx >= DEPTH);
            if (bus.we && widx < DEPTH) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.wstrb[b]) model_mem[widx[9:0]][b*8 +: 8] = bus.wdata[b*8 +: 8];
                end
                if (bus.wstrb[0]) model_perr[widx[9:0]] = 1'b0;
            end
        end
    end

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 99);
        if (r < 70)      return {$urandom_range(0, 63), 2'b00};
        else if (r < 80) return {$urandom_range(0, 63), 2'($urandom_range(1, 3))};
        else if (r < 90) return {$urandom_range(1024, 1100), 2'b00};
        else             return $urandom;
    endfunction

    initial begin
        rst_ni     = 1'b0;
        bus.req    = 1'b0;
        bus.addr   = 32'h0;
        bus.rready = 1'b0;
        bus.we     = 1'b0;
        bus.waddr  = 32'h0;
        bus.wdata  = 32'h0;
        bus.wstrb  = 4'h0;

        repeat (2) @(negedge clk_i);
        checkOutput("reset_rvalid", 32'(bus.rvalid), 32'h0);
        checkOutput("reset_rdata", bus.rdata, 32'h0);
        checkOutput("reset_rerr", 32'(bus.rerr), 32'h0);
        checkOutput("reset_wr_err", 32'(bus.wr_err), 32'h0);
        checkOutput("reset_cnt", 32'(fetch_cnt), 32'h0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // Preload word k = 0x1000_0000 + k through the loader port.
        for (int k = 0; k < DEPTH; k++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'(k * 4), 32'h1000_0000 + 32'(k), 4'hF);
        end
        idle(1'b1);

        // Three consecutive fetches with rready held high.
        fetch(32'h0, 1'b1);
        fetch(32'h4, 1'b1);
        @(negedge clk_i);
        checkOutput("seq0_rvalid", 32'(bus.rvalid), 32'h1);
        checkOutput("seq0_rdata", bus.rdata, 32'h1000_0000);
        fetch(32'h8, 1'b1);
        @(negedge clk_i);
        checkOutput("seq1_rdata", bus.rdata, 32'h1000_0001);
        idle(1'b1);
        @(negedge clk_i);
        checkOutput("seq2_rdata", bus.rdata, 32'h1000_0002);
        checkOutput("seq2_rerr", 32'(bus.rerr), 32'h0);
        checkOutput("seq_cnt", 32'(fetch_cnt), 32'h3);
        idle(1'b1);

        // Back-pressure holds the response and blocks the next request.
        fetch(32'h10, 1'b0);
        for (int i = 0; i < 3; i++) begin
            fetch(32'h14, 1'b0);
            @(negedge clk_i);
            checkOutput("bp_req_ready", 32'(bus.req_ready), 32'h0);
            checkOutput("bp_rdata", bus.rdata, 32'h1000_0004);
        end
        fetch(32'h14, 1'b1);
        idle(1'b1);
        @(negedge clk_i);
        checkOutput("bp_next_rdata", bus.rdata, 32'h1000_0005);
        idle(1'b1);

        // Misaligned, out-of-range fetch and out-of-range write.
        fetch(32'h2, 1'b1);
        idle(1'b1);
        @(negedge clk_i);
        checkOutput("misalign_rerr", 32'(bus.rerr), 32'h1);
        checkOutput("misalign_rdata", bus.rdata, 32'h0);
        fetch(32'h1000, 1'b1);
        idle(1'b1);
        @(negedge clk_i);
        checkOutput("oor_rerr", 32'(bus.rerr), 32'h1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h1000, 32'hDEAD_BEEF, 4'hF);
        idle(1'b1);
        @(negedge clk_i);
        checkOutput("oor_wr_err", 32'(bus.wr_err), 32'h1);
        idle(1'b1);
        @(negedge clk_i);
        checkOutput("oor_wr_err_pulse", 32'(bus.wr_err), 32'h0);

        // Strobed write with a same-cycle fetch of the same word.
        applyStimulus(1'b1, 32'h20, 1'b1, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101);
        fetch(32'h20, 1'b1);
        @(negedge clk_i);
        checkOutput("rbw_rdata", bus.rdata, 32'h1000_0008);
        idle(1'b1);
        @(negedge clk_i);
        checkOutput("strb_rdata", bus.rdata, 32'h10BB_00DD);

        // Asynchronous reset while a response is held.
        fetch(32'h0, 1'b0);
        idle(1'b0);
        @(negedge clk_i);
        checkOutput("pre_rst_rvalid", 32'(bus.rvalid), 32'h1);
        @(posedge clk_i);
        #3 rst_ni = 1'b0;
        #1;
        checkOutput("async_rst_rvalid", 32'(bus.rvalid), 32'h0);
        checkOutput("async_rst_cnt", 32'(fetch_cnt), 32'h0);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        fetch(32'h4, 1'b1);
        idle(1'b1);
        @(negedge clk_i);
        checkOutput("post_rst_rvalid", 32'(bus.rvalid), 32'h1);
        checkOutput("post_rst_rdata", bus.rdata, 32'h1000_0001);
        checkOutput("post_rst_cnt", 32'(fetch_cnt), 32'h1);

        // Corrupt stored parity of word 3 (only meaningful with parity storage).
        idle(1'b1);
`ifdef IMEM_PARITY_EN
        dut.mem_par[3][0] = ~dut.mem_par[3][0];
        model_perr[3] = 1'b1;
`endif
        fetch(32'hC, 1'b1);
        idle(1'b1);
        @(negedge clk_i);
        checkOutput("parity_rdata", bus.rdata, 32'h1000_0003);
        checkOutput("parity_rerr", 32'(bus.rerr), PAR ? 32'h1 : 32'h0);

        // Random traffic, with one reset pulse in the middle.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                idle(1'b0);
                #2 rst_ni = 1'b0;
                repeat (2) @(posedge clk_i);
                #1 rst_ni = 1'b1;
            end
            applyStimulus(($urandom_range(0, 99) < 70), rand_addr(),
                          ($urandom_range(0, 99) < 65),
                          ($urandom_range(0, 99) < 30), rand_addr(),
                          $urandom, 4'($urandom));
        end
        idle(1'b1);
        idle(1'b1);
        @(negedge clk_i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
